// File: rtl/xor_descrambler_8bit.sv
// Additive descrambler: 8-bit Galois LFSR keystream XORed onto DIN, re-seeded each frame.
// One registered output stage; DIN accepted at edge N is on DOUT after N; a stalled output holds and drops IN_READY.
module xor_descrambler_8bit #(
  parameter logic [7:0] POLY         = 8'hB8,
  parameter logic [7:0] SEED_DEFAULT = 8'hFF,
  parameter int         FRAME_LEN    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SEED_LOAD,
  input  logic [7:0]        SEED,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic signed [7:0] DIN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic signed [7:0] DOUT,
  output logic              DOUT_LAST
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      seed_reg;
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_step;
  logic [7:0]      seed_fix;
  logic [CW-1:0]   count;
  logic            accept;
  logic            frame_end;

  // An all-zero seed would lock the LFSR at zero forever.
  assign seed_fix  = (SEED == 8'h00) ? 8'h01 : SEED;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? POLY : 8'h00);
  assign accept    = IN_VALID && IN_READY;
  assign frame_end = (count == LAST_IDX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SEED_LOAD) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = 1'b0;
    if (state == RUN && !SEED_LOAD && (!OUT_VALID || OUT_READY)) begin
      IN_READY = 1'b1;
    end
  end

  // Keystream and frame position; a seed load overrides any step that cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seed_reg <= SEED_DEFAULT;
      lfsr     <= 8'h00;
      count    <= '0;
    end else if (SEED_LOAD) begin
      seed_reg <= seed_fix;
      lfsr     <= seed_fix;
      count    <= '0;
    end else if (accept) begin
      if (frame_end) begin
        lfsr  <= seed_reg;
        count <= '0;
      end else begin
        lfsr  <= lfsr_step;
        count <= count + 1'b1;
      end
    end
  end

  // Output stage: a new byte replaces the consumed one in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      DOUT      <= 8'sh00;
      DOUT_LAST <= 1'b0;
    end else if (accept) begin
      OUT_VALID <= 1'b1;
      DOUT      <= DIN ^ $signed(lfsr);
      DOUT_LAST <= frame_end;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

  a_hold_when_stalled: assert property (@(posedge CLK) disable iff (RST)
    (OUT_VALID && !OUT_READY) |=> (OUT_VALID && $stable(DOUT) && $stable(DOUT_LAST)));

  a_no_ready_when_stalled: assert property (@(posedge CLK) disable iff (RST)
    (OUT_VALID && !OUT_READY) |-> !IN_READY);

endmodule

// File: tb/tb_xor_descrambler_8bit.sv
// Directed bench for xor_descrambler_8bit: keystream, round trip, backpressure, zero seed, reseed, reset.
module tb_xor_descrambler_8bit;

  logic              CLK = 1'b0;
  logic              RST;
  logic              SEED_LOAD;
  logic [7:0]        SEED;
  logic              IN_VALID;
  logic              IN_READY;
  logic signed [7:0] DIN;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic signed [7:0] DOUT;
  logic              DOUT_LAST;

  int n_tests = 0;
  int n_fail  = 0;

  xor_descrambler_8bit dut (
    .CLK       (CLK),
    .RST       (RST),
    .SEED_LOAD (SEED_LOAD),
    .SEED      (SEED),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DIN       (DIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DOUT      (DOUT),
    .DOUT_LAST (DOUT_LAST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Transmit-side keystream step, used only to build scrambled stimulus.
  function automatic logic [7:0] tx_next(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic load_seed(input logic [7:0] s);
    SEED_LOAD = 1'b1;
    SEED      = s;
    IN_VALID  = 1'b0;
    step();
    SEED_LOAD = 1'b0;
  endtask

  logic [7:0] ks1 [4] = '{8'hFF, 8'hC7, 8'hDB, 8'hD5};
  logic [7:0] key;

  initial begin
    RST = 1'b1; SEED_LOAD = 1'b0; SEED = 8'h00;
    IN_VALID = 1'b0; DIN = 8'sh00; OUT_READY = 1'b1;
    step(); step();
    RST = 1'b0;
    chk("rst_out_valid", {7'd0, OUT_VALID}, 8'h00);
    chk("rst_dout",      DOUT,              8'h00);
    chk("rst_last",      {7'd0, DOUT_LAST}, 8'h00);
    chk("rst_in_ready",  {7'd0, IN_READY},  8'h00);

    // IDLE gating: nothing accepted before a seed load.
    IN_VALID = 1'b1; DIN = 8'sh55;
    #1 chk("idle_in_ready", {7'd0, IN_READY}, 8'h00);
    step();
    chk("idle_no_accept", {7'd0, OUT_VALID}, 8'h00);

    // Keystream after seeding with FF.
    load_seed(8'hFF);
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; DIN = 8'sh00;
      #1 chk("ks_in_ready", {7'd0, IN_READY}, 8'h01);
      step();
      chk("ks_dout",  DOUT, ks1[i]);
      chk("ks_valid", {7'd0, OUT_VALID}, 8'h01);
    end
    IN_VALID = 1'b0;
    step();
    chk("ks_drained", {7'd0, OUT_VALID}, 8'h00);

    // Zero seed is replaced by 01.
    load_seed(8'h00);
    IN_VALID = 1'b1; DIN = 8'sh00;
    step();
    chk("zseed_k0", DOUT, 8'h01);
    step();
    chk("zseed_k1", DOUT, 8'hB8);
    IN_VALID = 1'b0;
    step();

    // Round trip with seed A5: 16-byte frame, 17th byte restarts at A5.
    load_seed(8'hA5);
    key = 8'hA5;
    for (int i = 0; i < 17; i++) begin
      logic [7:0] pt;
      pt = (i < 16) ? 8'(i) : 8'h11;
      if (i == 16) chk("rt_key_reseed", key, 8'hA5);
      IN_VALID = 1'b1; DIN = $signed(pt ^ key);
      step();
      chk("rt_dout", DOUT, pt);
      chk("rt_last", {7'd0, DOUT_LAST}, (i == 15) ? 8'h01 : 8'h00);
      key = (i == 15) ? 8'hA5 : tx_next(key);
    end
    IN_VALID = 1'b0;
    step();

    // Backpressure: 3C held for three stalled cycles, then 77 follows without a bubble.
    load_seed(8'hFF);
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; DIN = $signed(8'h3C ^ 8'hFF);
    step();
    DIN = $signed(8'h77 ^ 8'hC7);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {7'd0, IN_READY},  8'h00);
      chk("bp_dout",     DOUT,              8'h3C);
      chk("bp_valid",    {7'd0, OUT_VALID}, 8'h01);
      step();
    end
    OUT_READY = 1'b1;
    #1 chk("bp_release_ready", {7'd0, IN_READY}, 8'h01);
    step();
    chk("bp_next_dout",  DOUT,              8'h77);
    chk("bp_next_valid", {7'd0, OUT_VALID}, 8'h01);
    IN_VALID = 1'b0;
    step();
    chk("bp_drained", {7'd0, OUT_VALID}, 8'h00);

    // Mid-frame reseed after 5 bytes.
    load_seed(8'hFF);
    IN_VALID = 1'b1; DIN = 8'sh00;
    for (int i = 0; i < 5; i++) step();
    SEED_LOAD = 1'b1; SEED = 8'h5A;
    #1 chk("rs_in_ready", {7'd0, IN_READY}, 8'h00);
    step();
    SEED_LOAD = 1'b0;
    chk("rs_held_drained", {7'd0, OUT_VALID}, 8'h00);
    key = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("rs_dout", DOUT, key);
      chk("rs_last", {7'd0, DOUT_LAST}, (i == 15) ? 8'h01 : 8'h00);
      key = tx_next(key);
    end

    // Reset mid-operation: output valid, then synchronous reset.
    OUT_READY = 1'b0;
    step();
    chk("mr_valid_before", {7'd0, OUT_VALID}, 8'h01);
    RST = 1'b1;
    #1 chk("mr_sync_only", {7'd0, OUT_VALID}, 8'h01);
    step();
    RST = 1'b0;
    chk("mr_valid",    {7'd0, OUT_VALID}, 8'h00);
    chk("mr_dout",     DOUT,              8'h00);
    chk("mr_last",     {7'd0, DOUT_LAST}, 8'h00);
    chk("mr_in_ready", {7'd0, IN_READY},  8'h00);
    step();
    chk("mr_idle_no_accept", {7'd0, OUT_VALID}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
